box_motion: RTL and testbench

BOX_MOTION -- requirements
Module: box_motion

---
 rtl/box_pkg.sv | 49 ++++
 rtl/frame_tick_gen.sv | 39 +++
 rtl/box_motion.sv | 108 ++++++++++
 tb/tb_box_motion.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/box_pkg.sv
// Shared screen geometry, keycodes, state encoding and per-axis bounce helper for the box mover.
package box_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned COORD_W  = 10;
    localparam int unsigned SCOORD_W = 11;

    localparam logic [7:0] KEY_NONE = 8'h00;
    localparam logic [7:0] KEY_W    = 8'h1A;
    localparam logic [7:0] KEY_S    = 8'h16;
    localparam logic [7:0] KEY_A    = 8'h04;
    localparam logic [7:0] KEY_D    = 8'h07;

    localparam logic signed [SCOORD_W-1:0] S_ZERO = '0;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0]         pos;
        logic signed [SCOORD_W-1:0] vel;
    } axis_t;

    // One axis step: move by vel, and on a wall hit clamp to the wall and reverse.
    function automatic axis_t step_axis(input logic [COORD_W-1:0]         pos,
                                        input logic signed [SCOORD_W-1:0] vel,
                                        input logic [COORD_W-1:0]         half,
                                        input logic signed [SCOORD_W-1:0] edge_max);
        logic signed [SCOORD_W-1:0] nxt;
        logic signed [SCOORD_W-1:0] half_s;
        axis_t                      r;
        half_s = $signed({1'b0, half});
        nxt    = $signed({1'b0, pos}) + vel;
        r.pos  = COORD_W'(nxt);
        r.vel  = vel;
        if ((nxt + half_s) > edge_max) begin
            r.pos = COORD_W'(edge_max - half_s);
            r.vel = -vel;
        end else if ((nxt - half_s) < S_ZERO) begin
            r.pos = half;
            r.vel = -vel;
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the asynchronous frame strobe into Clk and emits a one-cycle pulse per rising edge.
module frame_tick_gen
    import box_pkg::*;
(
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic frame_tick
);

    logic sync1;
    logic sync2;
    logic hist;
    logic valid1;
    logic valid2;
    logic armed;

    // armed only after a genuine low has come through, so a strobe already high at release is ignored
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            hist   <= 1'b0;
            valid1 <= 1'b0;
            valid2 <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync1  <= frame_clk;
            sync2  <= sync1;
            hist   <= sync2;
            valid1 <= 1'b1;
            valid2 <= valid1;
            armed  <= armed | (valid2 & ~sync2);
        end
    end

    assign frame_tick = sync2 & ~hist & armed;

endmodule

// File: rtl/box_motion.sv
// Moves a box one step per frame under keyboard control, bouncing off the screen edges.
module box_motion
    import box_pkg::*;
#(
    parameter logic [COORD_W-1:0] HALF_W  = 10'd16,
    parameter logic [COORD_W-1:0] HALF_H  = 10'd16,
    parameter logic [COORD_W-1:0] START_X = 10'd320,
    parameter logic [COORD_W-1:0] START_Y = 10'd240,
    parameter logic [COORD_W-1:0] STEP    = 10'd2
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_clk,
    input  logic [7:0]         keycode,
    input  logic               run_en,
    output logic [COORD_W-1:0] CX,
    output logic [COORD_W-1:0] CY,
    output logic [COORD_W-1:0] X_width,
    output logic [COORD_W-1:0] Y_height,
    output logic               moving
);

    localparam logic signed [SCOORD_W-1:0] X_MAX  = SCOORD_W'(SCREEN_W - 1);
    localparam logic signed [SCOORD_W-1:0] Y_MAX  = SCOORD_W'(SCREEN_H - 1);
    localparam logic signed [SCOORD_W-1:0] STEP_S = $signed({1'b0, STEP});

    logic                       frame_tick;
    state_t                     state;
    state_t                     state_nxt;
    logic signed [SCOORD_W-1:0] vx;
    logic signed [SCOORD_W-1:0] vy;
    logic signed [SCOORD_W-1:0] vx_key;
    logic signed [SCOORD_W-1:0] vy_key;
    logic signed [SCOORD_W-1:0] vx_nxt;
    logic signed [SCOORD_W-1:0] vy_nxt;
    logic [COORD_W-1:0]         cx_nxt;
    logic [COORD_W-1:0]         cy_nxt;
    axis_t                      ax;
    axis_t                      ay;

    frame_tick_gen u_frame_tick_gen (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    assign X_width  = HALF_W;
    assign Y_height = HALF_H;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= STOP;
            moving <= 1'b0;
        end else if (frame_tick) begin
            state  <= state_nxt;
            moving <= (state_nxt == RUN);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            CX <= START_X;
            CY <= START_Y;
            vx <= '0;
            vy <= '0;
        end else if (frame_tick) begin
            CX <= cx_nxt;
            CY <= cy_nxt;
            vx <= vx_nxt;
            vy <= vy_nxt;
        end
    end

    // Key picks the velocity first; any wall hit then overrides it so the box heads inward.
    always_comb begin
        state_nxt = state;
        vx_key    = vx;
        vy_key    = vy;
        ax        = '0;
        ay        = '0;
        case (keycode)
            KEY_W:   begin vx_key = '0;      vy_key = -STEP_S; end
            KEY_S:   begin vx_key = '0;      vy_key = STEP_S;  end
            KEY_A:   begin vx_key = -STEP_S; vy_key = '0;      end
            KEY_D:   begin vx_key = STEP_S;  vy_key = '0;      end
            default: ;
        endcase
        case (state)
            STOP:    if (run_en && ((vx_key != S_ZERO) || (vy_key != S_ZERO))) state_nxt = RUN;
            RUN:     if (!run_en) state_nxt = STOP;
            default: state_nxt = STOP;
        endcase
        cx_nxt = CX;
        cy_nxt = CY;
        vx_nxt = vx_key;
        vy_nxt = vy_key;
        if (state_nxt == RUN) begin
            ax     = step_axis(CX, vx_key, HALF_W, X_MAX);
            ay     = step_axis(CY, vy_key, HALF_H, Y_MAX);
            cx_nxt = ax.pos;
            cy_nxt = ay.pos;
            vx_nxt = ax.vel;
            vy_nxt = ay.vel;
        end
    end

endmodule

// File: tb/tb_box_motion.sv
// Self-checking bench for box_motion against a plain-arithmetic model of the box's motion.
module tb_box_motion;

    localparam int HW   = 16;
    localparam int HH   = 16;
    localparam int STEP = 2;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_clk;
    logic [7:0] keycode;
    logic       run_en;
    logic [9:0] CX;
    logic [9:0] CY;
    logic [9:0] X_width;
    logic [9:0] Y_height;
    logic       moving;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_cx, m_cy, m_vx, m_vy;
    bit m_run;

    box_motion dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .keycode   (keycode),
        .run_en    (run_en),
        .CX        (CX),
        .CY        (CY),
        .X_width   (X_width),
        .Y_height  (Y_height),
        .moving    (moving)
    );

    always #5 Clk = ~Clk;

    function automatic void model_reset();
        m_cx  = 320;
        m_cy  = 240;
        m_vx  = 0;
        m_vy  = 0;
        m_run = 1'b0;
    endfunction

    function automatic void model_tick(input logic [7:0] key, input bit en);
        int nx, ny;
        case (key)
            8'h1A: begin m_vx = 0;     m_vy = -STEP; end
            8'h16: begin m_vx = 0;     m_vy = STEP;  end
            8'h04: begin m_vx = -STEP; m_vy = 0;     end
            8'h07: begin m_vx = STEP;  m_vy = 0;     end
            default: ;
        endcase
        if (m_run) m_run = en;
        else       m_run = en && (m_vx != 0 || m_vy != 0);
        if (m_run) begin
            nx = m_cx + m_vx;
            ny = m_cy + m_vy;
            if (nx + HW > 639)    begin m_cx = 639 - HW; m_vx = -m_vx; end
            else if (nx - HW < 0) begin m_cx = HW;       m_vx = -m_vx; end
            else                  m_cx = nx;
            if (ny + HH > 479)    begin m_cy = 479 - HH; m_vy = -m_vy; end
            else if (ny - HH < 0) begin m_cy = HH;       m_vy = -m_vy; end
            else                  m_cy = ny;
        end
    endfunction

    // One full frame strobe period with key/run_en held steady; model advances one tick.
    task automatic frame(input logic [7:0] key, input bit en);
        keycode   = key;
        run_en    = en;
        frame_clk = 1'b1;
        repeat (5) @(posedge Clk);
        frame_clk = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        model_tick(key, en);
    endtask

    task automatic do_reset();
        frame_clk = 1'b0;
        Reset_n   = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        keycode   = 8'h07;
        run_en    = 1'b1;
        frame_clk = 1'b1;
        Reset_n   = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        n_cmp++; if (CX !== 10'd320) begin n_fail++; $display("FAIL reset_cx: got %0d want 320", CX); end
        n_cmp++; if (CY !== 10'd240) begin n_fail++; $display("FAIL reset_cy: got %0d want 240", CY); end
        n_cmp++; if (moving !== 1'b0) begin n_fail++; $display("FAIL reset_moving: got %b want 0", moving); end
        n_cmp++; if (X_width !== 10'd16) begin n_fail++; $display("FAIL reset_xwidth: got %0d want 16", X_width); end
        n_cmp++; if (Y_height !== 10'd16) begin n_fail++; $display("FAIL reset_yheight: got %0d want 16", Y_height); end
        Reset_n = 1'b1;
        repeat (12) @(posedge Clk);
        #1;
        n_cmp++; if (CX !== 10'd320) begin n_fail++; $display("FAIL release_high_cx: got %0d want 320", CX); end
        n_cmp++; if (moving !== 1'b0) begin n_fail++; $display("FAIL release_high_moving: got %b want 0", moving); end
        frame_clk = 1'b0;
        repeat (5) @(posedge Clk);
        model_reset();
        frame(8'h07, 1'b1);
        n_cmp++; if (CX !== 10'd322) begin n_fail++; $display("FAIL first_edge_cx: got %0d want 322", CX); end
        n_cmp++; if (moving !== 1'b1) begin n_fail++; $display("FAIL first_edge_moving: got %b want 1", moving); end
    endtask

    task automatic test_run_right();
        do_reset();
        repeat (5) frame(8'h07, 1'b1);
        n_cmp++; if (CX !== 10'd330) begin n_fail++; $display("FAIL run_right_cx: got %0d want 330", CX); end
        n_cmp++; if (CY !== 10'd240) begin n_fail++; $display("FAIL run_right_cy: got %0d want 240", CY); end
        n_cmp++; if (moving !== 1'b1) begin n_fail++; $display("FAIL run_right_moving: got %b want 1", moving); end
    endtask

    task automatic test_right_wall();
        for (int i = 0; i < 200 && m_cx != 622; i++) begin
            frame(8'h07, 1'b1);
            n_cmp++; if (CX !== 10'(m_cx)) begin n_fail++; $display("FAIL walk_right_cx: got %0d want %0d", CX, m_cx); end
        end
        n_cmp++; if (CX !== 10'd622) begin n_fail++; $display("FAIL near_right_wall_cx: got %0d want 622", CX); end
        frame(8'h07, 1'b1);
        n_cmp++; if (CX !== 10'd623) begin n_fail++; $display("FAIL right_bounce_cx: got %0d want 623", CX); end
        frame(8'h00, 1'b1);
        n_cmp++; if (CX !== 10'd621) begin n_fail++; $display("FAIL right_rebound_cx: got %0d want 621", CX); end
    endtask

    task automatic test_top_wall();
        for (int i = 0; i < 200 && m_cy != 463; i++) begin
            frame(8'h16, 1'b1);
            n_cmp++; if (CY !== 10'(m_cy)) begin n_fail++; $display("FAIL walk_down_cy: got %0d want %0d", CY, m_cy); end
        end
        n_cmp++; if (CY !== 10'd463) begin n_fail++; $display("FAIL bottom_bounce_cy: got %0d want 463", CY); end
        for (int i = 0; i < 300 && m_cy != 17; i++) begin
            frame(8'h00, 1'b1);
            n_cmp++; if (CY !== 10'(m_cy)) begin n_fail++; $display("FAIL walk_up_cy: got %0d want %0d", CY, m_cy); end
        end
        n_cmp++; if (CY !== 10'd17) begin n_fail++; $display("FAIL near_top_cy: got %0d want 17", CY); end
        frame(8'h1A, 1'b1);
        n_cmp++; if (CY !== 10'd16) begin n_fail++; $display("FAIL top_bounce_cy: got %0d want 16", CY); end
        frame(8'h00, 1'b1);
        n_cmp++; if (CY !== 10'd18) begin n_fail++; $display("FAIL wall_beats_key_cy: got %0d want 18", CY); end
    endtask

    task automatic test_freeze();
        logic [9:0] hold_x, hold_y;
        hold_x = CX;
        hold_y = CY;
        frame(8'h00, 1'b0);
        n_cmp++; if (moving !== 1'b0) begin n_fail++; $display("FAIL freeze_moving: got %b want 0", moving); end
        for (int i = 0; i < 3; i++) begin
            frame(8'h00, 1'b0);
            n_cmp++; if (CX !== hold_x || CY !== hold_y) begin
                n_fail++; $display("FAIL freeze_hold: got (%0d,%0d) want (%0d,%0d)", CX, CY, hold_x, hold_y);
            end
        end
        frame(8'h00, 1'b1);
        n_cmp++; if (CY !== hold_y + 10'd2 || CX !== hold_x) begin
            n_fail++; $display("FAIL resume_pos: got (%0d,%0d) want (%0d,%0d)", CX, CY, hold_x, hold_y + 10'd2);
        end
        n_cmp++; if (moving !== 1'b1) begin n_fail++; $display("FAIL resume_moving: got %b want 1", moving); end
    endtask

    task automatic test_random();
        logic [7:0] keys [5];
        logic [7:0] k;
        bit         en;
        keys[0] = 8'h00; keys[1] = 8'h1A; keys[2] = 8'h16; keys[3] = 8'h04; keys[4] = 8'h07;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) k = 8'($urandom);
            else                           k = keys[$urandom_range(0, 4)];
            en = ($urandom_range(0, 9) != 0);
            frame(k, en);
            n_cmp++; if (CX !== 10'(m_cx) || CY !== 10'(m_cy) || moving !== m_run) begin
                n_fail++;
                $display("FAIL random_frame%0d: got (%0d,%0d,%b) want (%0d,%0d,%b)", i, CX, CY, moving, m_cx, m_cy, m_run);
            end
        end
    endtask

    task automatic test_reset_mid();
        frame(8'h07, 1'b1);
        keycode   = 8'h07;
        run_en    = 1'b1;
        frame_clk = 1'b1;
        @(posedge Clk);
        #1 Reset_n = 1'b0;
        #1;
        n_cmp++; if (CX !== 10'd320 || CY !== 10'd240) begin
            n_fail++; $display("FAIL mid_reset_pos: got (%0d,%0d) want (320,240)", CX, CY);
        end
        n_cmp++; if (moving !== 1'b0) begin n_fail++; $display("FAIL mid_reset_moving: got %b want 0", moving); end
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;
        repeat (8) @(posedge Clk);
        #1;
        n_cmp++; if (CX !== 10'd320 || moving !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_no_tick: got (%0d,%b) want (320,0)", CX, moving);
        end
        frame_clk = 1'b0;
        repeat (5) @(posedge Clk);
        model_reset();
        frame(8'h04, 1'b1);
        n_cmp++; if (CX !== 10'd318 || CY !== 10'(m_cy)) begin
            n_fail++; $display("FAIL after_reset_move: got (%0d,%0d) want (318,%0d)", CX, CY, m_cy);
        end
    endtask

    initial begin
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        keycode   = 8'h00;
        run_en    = 1'b0;
        model_reset();
        test_reset();
        test_run_right();
        test_right_wall();
        test_top_wall();
        test_freeze();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
